game_seq_ctrl: RTL and testbench

GAME_SEQ_CTRL -- requirements
Module: game_seq_ctrl

---
 rtl/game_pkg.sv | 38 +++
 rtl/game_seq_ctrl_key_edge.sv | 27 ++
 rtl/game_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_game_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the stacking game: controller state encoding,
// per-level block speed table and the default game dimensions that the
// graphics unit and the sequence controller both rely on.
package game_pkg;

  // Default game dimensions
  localparam int DEF_ROWS_PER_LEVEL = 8;
  localparam int DEF_NUM_LEVELS     = 4;
  localparam int DEF_INIT_WIDTH     = 160;
  localparam int DEF_FALL_TIMEOUT   = 120;
  localparam int DEF_LEVEL_HOLD     = 60;

  // Key bit positions inside the dropper bus
  localparam int KEY_DROP  = 0;
  localparam int KEY_START = 1;
  localparam int KEY_PAUSE = 2;

  // Game sequence states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_PAUSE,
    ST_FALL,
    ST_CHECK,
    ST_LVLUP,
    ST_WIN,
    ST_LOSE
  } game_state_t;

  // Horizontal block speed in px per frame, indexed by level
  localparam logic [3:0] SPEED_TABLE [4] = '{4'd2, 4'd3, 4'd4, 4'd6};

  // Looks up the block speed for a given level
  function automatic logic [3:0] speed_for_level(input logic [1:0] lvl);
    return SPEED_TABLE[lvl];
  endfunction

endpackage

// File: rtl/game_seq_ctrl_key_edge.sv
// Registers the level-held keyboard keys and turns each press into a single
// one-cycle pulse. Keys already held while reset is asserted are masked until
// they are released, so releasing reset never looks like a fresh press.
module key_edge (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keys,
  output logic [3:0] edges
);

  logic [3:0] key_q;
  logic [3:0] blocked;

  // Key history, held-through-reset mask and registered rising-edge pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q   <= 4'b0000;
      blocked <= keys;
      edges   <= 4'b0000;
    end else begin
      key_q   <= keys;
      blocked <= blocked & keys;
      edges   <= keys & ~key_q & ~blocked;
    end
  end

endmodule

// File: rtl/game_seq_ctrl.sv
// Game sequence controller for the block stacking game. Tracks play, pause,
// falling, landing evaluation and level progression, and produces the
// registered run/drop/speed/width/score/result outputs for the graphics unit.
module game_seq_ctrl
  import game_pkg::*;
#(
  parameter int ROWS_PER_LEVEL = DEF_ROWS_PER_LEVEL,
  parameter int NUM_LEVELS     = DEF_NUM_LEVELS,
  parameter int INIT_WIDTH     = DEF_INIT_WIDTH,
  parameter int FALL_TIMEOUT   = DEF_FALL_TIMEOUT,
  parameter int LEVEL_HOLD     = DEF_LEVEL_HOLD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dropper,
  input  logic       frame_tick,
  input  logic       land_valid,
  input  logic [9:0] land_overlap,
  output logic       run,
  output logic       drop_req,
  output logic [3:0] speed,
  output logic [9:0] blk_width,
  output logic [1:0] level,
  output logic [3:0] row,
  output logic [7:0] score,
  output logic       win,
  output logic       lose
);

  localparam logic [3:0] ROW_LIMIT  = 4'(ROWS_PER_LEVEL);
  localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
  localparam logic [9:0] INIT_W     = 10'(INIT_WIDTH);
  localparam logic [7:0] FALL_LIMIT = 8'(FALL_TIMEOUT);
  localparam logic [7:0] HOLD_LIMIT = 8'(LEVEL_HOLD);

  game_state_t state;
  logic [3:0]  key_edges;
  logic [7:0]  frame_cnt;
  logic [7:0]  frame_inc;
  logic [9:0]  overlap;
  logic [9:0]  overlap_min;
  logic [3:0]  row_inc;
  logic [7:0]  score_inc;
  logic        hold_active;
  logic        drop_edge;
  logic        start_edge;
  logic        pause_edge;
  logic        unused_key;

  key_edge u_key_edge (
    .clk   (clk),
    .reset (reset),
    .keys  (dropper),
    .edges (key_edges)
  );

  assign drop_edge  = key_edges[KEY_DROP];
  assign start_edge = key_edges[KEY_START];
  assign pause_edge = key_edges[KEY_PAUSE];
  assign unused_key = key_edges[3];

  assign frame_inc   = (frame_cnt == 8'hFF) ? frame_cnt : frame_cnt + 8'd1;
  assign score_inc   = (score == 8'hFF) ? score : score + 8'd1;
  assign row_inc     = row + 4'd1;
  assign overlap_min = (land_overlap < blk_width) ? land_overlap : blk_width;

  // Game sequence FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      run         <= 1'b0;
      drop_req    <= 1'b0;
      speed       <= speed_for_level(2'd0);
      blk_width   <= INIT_W;
      level       <= 2'd0;
      row         <= 4'd0;
      score       <= 8'd0;
      win         <= 1'b0;
      lose        <= 1'b0;
      frame_cnt   <= 8'd0;
      overlap     <= 10'd0;
      hold_active <= 1'b0;
    end else begin
      drop_req <= 1'b0;
      if (frame_tick) begin
        frame_cnt <= frame_inc;
      end

      case (state)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (start_edge) begin
            state     <= ST_PLAY;
            run       <= 1'b1;
            level     <= 2'd0;
            row       <= 4'd0;
            score     <= 8'd0;
            blk_width <= INIT_W;
            speed     <= speed_for_level(2'd0);
            win       <= 1'b0;
            lose      <= 1'b0;
          end
        end

        ST_PLAY: begin
          if (drop_edge) begin
            drop_req  <= 1'b1;
            frame_cnt <= 8'd0;
            run       <= 1'b0;
            state     <= ST_FALL;
          end else if (pause_edge) begin
            run   <= 1'b0;
            state <= ST_PAUSE;
          end
        end

        ST_PAUSE: begin
          if (pause_edge) begin
            run   <= 1'b1;
            state <= ST_PLAY;
          end
        end

        ST_FALL: begin
          if (land_valid) begin
            overlap <= overlap_min;
            state   <= ST_CHECK;
          end else if (frame_tick && (frame_inc >= FALL_LIMIT)) begin
            lose  <= 1'b1;
            state <= ST_LOSE;
          end
        end

        ST_CHECK: begin
          if (overlap == 10'd0) begin
            lose  <= 1'b1;
            state <= ST_LOSE;
          end else begin
            blk_width <= overlap;
            row       <= row_inc;
            score     <= score_inc;
            if (row_inc == ROW_LIMIT) begin
              hold_active <= 1'b0;
              state       <= ST_LVLUP;
            end else begin
              run   <= 1'b1;
              state <= ST_PLAY;
            end
          end
        end

        ST_LVLUP: begin
          if (!hold_active) begin
            if (level == LAST_LEVEL) begin
              win   <= 1'b1;
              state <= ST_WIN;
            end else begin
              level       <= level + 2'd1;
              speed       <= speed_for_level(level + 2'd1);
              row         <= 4'd0;
              blk_width   <= INIT_W;
              frame_cnt   <= 8'd0;
              hold_active <= 1'b1;
            end
          end else if (frame_tick && (frame_inc >= HOLD_LIMIT)) begin
            hold_active <= 1'b0;
            run         <= 1'b1;
            state       <= ST_PLAY;
          end
        end

        default: begin
          run   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed self-checking bench for the game sequence controller: reset
// values, start, drop/land, pause, zero-overlap loss, fall timeout, a full
// four-level game to a win, and reset during a fall with a key held.
module tb_game_seq_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] dropper;
  logic       frame_tick;
  logic       land_valid;
  logic [9:0] land_overlap;
  logic       run;
  logic       drop_req;
  logic [3:0] speed;
  logic [9:0] blk_width;
  logic [1:0] level;
  logic [3:0] row;
  logic [7:0] score;
  logic       win;
  logic       lose;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_speed [4] = '{4'd2, 4'd3, 4'd4, 4'd6};

  localparam logic [3:0] K_DROP  = 4'b0001;
  localparam logic [3:0] K_START = 4'b0010;
  localparam logic [3:0] K_PAUSE = 4'b0100;

  game_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .dropper      (dropper),
    .frame_tick   (frame_tick),
    .land_valid   (land_valid),
    .land_overlap (land_overlap),
    .run          (run),
    .drop_req     (drop_req),
    .speed        (speed),
    .blk_width    (blk_width),
    .level        (level),
    .row          (row),
    .score        (score),
    .win          (win),
    .lose         (lose)
  );

  // 50 MHz system clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Guard against a stuck run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Press keys, wait until the controller has reacted, then release them
  task automatic applyStimulus(input logic [3:0] keys);
    dropper = dropper | keys;
    step();
    step();
    dropper = dropper & ~keys;
  endtask

  task automatic landBlock(input logic [9:0] ovl);
    land_valid   = 1'b1;
    land_overlap = ovl;
    step();
    land_valid   = 1'b0;
    land_overlap = 10'd0;
    step();
  endtask

  task automatic frameTicks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  // Linear directed test sequence
  initial begin
    reset        = 1'b1;
    dropper      = 4'b0000;
    frame_tick   = 1'b0;
    land_valid   = 1'b0;
    land_overlap = 10'd0;
    step();
    step();
    step();

    checkOutput("rst_run",   run,       0);
    checkOutput("rst_drop",  drop_req,  0);
    checkOutput("rst_speed", speed,     2);
    checkOutput("rst_width", blk_width, 160);
    checkOutput("rst_level", level,     0);
    checkOutput("rst_row",   row,       0);
    checkOutput("rst_score", score,     0);
    checkOutput("rst_win",   win,       0);
    checkOutput("rst_lose",  lose,      0);

    reset = 1'b0;
    applyStimulus(K_START);
    checkOutput("start_run",   run,       1);
    checkOutput("start_width", blk_width, 160);
    checkOutput("start_speed", speed,     2);
    checkOutput("start_score", score,     0);

    applyStimulus(K_DROP);
    checkOutput("drop_pulse", drop_req, 1);
    checkOutput("drop_run",   run,      0);
    step();
    checkOutput("drop_single", drop_req, 0);
    landBlock(10'd120);
    checkOutput("land120_width", blk_width, 120);
    checkOutput("land120_row",   row,       1);
    checkOutput("land120_score", score,     1);
    checkOutput("land120_run",   run,       1);

    applyStimulus(K_DROP);
    landBlock(10'd500);
    checkOutput("landbig_width", blk_width, 120);
    checkOutput("landbig_row",   row,       2);
    checkOutput("landbig_score", score,     2);

    applyStimulus(K_PAUSE);
    checkOutput("pause_run", run, 0);
    applyStimulus(K_DROP);
    checkOutput("pause_nodrop", drop_req, 0);
    checkOutput("pause_stay",   run,      0);
    applyStimulus(K_PAUSE);
    checkOutput("resume_run", run, 1);

    applyStimulus(K_DROP);
    landBlock(10'd0);
    checkOutput("zero_lose",  lose,  1);
    checkOutput("zero_run",   run,   0);
    checkOutput("zero_score", score, 2);
    applyStimulus(K_START);
    checkOutput("restart_run",   run,       1);
    checkOutput("restart_score", score,     0);
    checkOutput("restart_lose",  lose,      0);
    checkOutput("restart_width", blk_width, 160);
    checkOutput("restart_row",   row,       0);

    applyStimulus(K_DROP | K_PAUSE);
    checkOutput("both_drop", drop_req, 1);
    checkOutput("both_run",  run,      0);
    landBlock(10'd50);
    checkOutput("both_fall_row",   row,       1);
    checkOutput("both_fall_width", blk_width, 50);
    checkOutput("both_fall_run",   run,       1);

    land_valid   = 1'b1;
    land_overlap = 10'd0;
    step();
    land_valid   = 1'b0;
    step();
    checkOutput("stray_land_run",  run,  1);
    checkOutput("stray_land_lose", lose, 0);
    checkOutput("stray_land_row",  row,  1);

    applyStimulus(K_DROP);
    frameTicks(119);
    checkOutput("timeout_119_lose", lose, 0);
    frameTicks(1);
    checkOutput("timeout_120_lose", lose, 1);

    applyStimulus(K_START);
    checkOutput("game_level0", level, 0);
    for (int lev = 0; lev < 4; lev++) begin
      checkOutput($sformatf("game_level_%0d", lev), level, lev);
      checkOutput($sformatf("game_speed_%0d", lev), speed, exp_speed[lev]);
      for (int r = 0; r < 8; r++) begin
        applyStimulus(K_DROP);
        landBlock(10'd100);
      end
      checkOutput($sformatf("game_score_%0d", lev), score, (lev + 1) * 8);
      if (lev < 3) begin
        checkOutput($sformatf("lvlup_row8_%0d", lev), row, 8);
        checkOutput($sformatf("lvlup_run_%0d", lev),  run, 0);
        step();
        checkOutput($sformatf("lvlup_level_%0d", lev), level, lev + 1);
        checkOutput($sformatf("lvlup_row0_%0d", lev),  row, 0);
        checkOutput($sformatf("lvlup_width_%0d", lev), blk_width, 160);
        frameTicks(59);
        checkOutput($sformatf("hold59_run_%0d", lev), run, 0);
        frameTicks(1);
        checkOutput($sformatf("hold60_run_%0d", lev), run, 1);
      end else begin
        checkOutput("final_win_early", win, 0);
        step();
        checkOutput("final_win",  win,  1);
        checkOutput("final_lose", lose, 0);
        checkOutput("final_run",  run,  0);
      end
    end

    applyStimulus(K_START);
    checkOutput("after_win_win",   win,   0);
    checkOutput("after_win_score", score, 0);
    checkOutput("after_win_speed", speed, 2);
    checkOutput("after_win_level", level, 0);

    applyStimulus(K_DROP);
    checkOutput("midfall_drop", drop_req, 1);
    dropper = K_DROP;
    reset   = 1'b1;
    step();
    checkOutput("midfall_rst_run",   run,       0);
    checkOutput("midfall_rst_speed", speed,     2);
    checkOutput("midfall_rst_width", blk_width, 160);
    checkOutput("midfall_rst_score", score,     0);
    checkOutput("midfall_rst_lose",  lose,      0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("held_nodrop_%0d", i), drop_req, 0);
    end
    checkOutput("held_idle_run", run, 0);
    applyStimulus(K_START);
    checkOutput("held_start_run",  run,      1);
    checkOutput("held_start_drop", drop_req, 0);
    step();
    checkOutput("held_play_drop", drop_req, 0);
    checkOutput("held_play_run",  run,      1);
    dropper = 4'b0000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
